// File: rtl/subcarrier_map_pkg.sv
// Shared OFDM constants, read-FSM state type and the logical-subcarrier to
// IFFT-bin mapping used by subcarrier_map.
package ofdm_pkg;

    localparam int NFFT     = 64;
    localparam int N_USED   = 52;
    localparam int N_HALF   = 26;
    localparam int GUARD_LO = 27;
    localparam int GUARD_HI = 37;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_STREAM,
        RD_GAP
    } rd_state_e;

    // Sample k arrives in order -26..-1,+1..+26; negative carriers wrap to the top bins.
    function automatic logic [5:0] logical_to_bin(input logic [5:0] k);
        if (k < 6'(N_HALF))
            return k + 6'(NFFT - N_HALF);
        else
            return k - 6'(N_HALF - 1);
    endfunction

    function automatic logic is_null_bin(input logic [5:0] b);
        return (b == 6'd0) || ((b >= 6'(GUARD_LO)) && (b <= 6'(GUARD_HI)));
    endfunction

    function automatic logic [5:0] bitrev6(input logic [5:0] x);
        logic [5:0] r;
        for (int i = 0; i < 6; i++)
            r[i] = x[5-i];
        return r;
    endfunction

endpackage

// File: rtl/subcarrier_map_if.sv
// Streaming bus of subcarrier_map: pilot-insertion side in, IFFT side out.
interface subcarrier_map_if #(
    parameter int DATA_W = 16
);
    logic              din_valid;
    logic              din_ready;
    logic [DATA_W-1:0] din_real;
    logic [DATA_W-1:0] din_imag;
    logic              dout_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout_real;
    logic [DATA_W-1:0] dout_imag;
    logic [5:0]        dout_index;
    logic              dout_sop;
    logic              dout_eop;
    logic              overflow;

    modport slave (
        input  din_valid, din_real, din_imag, dout_ready,
        output din_ready, dout_valid, dout_real, dout_imag,
               dout_index, dout_sop, dout_eop, overflow
    );

    modport master (
        output din_valid, din_real, din_imag, dout_ready,
        input  din_ready, dout_valid, dout_real, dout_imag,
               dout_index, dout_sop, dout_eop, overflow
    );
endinterface

// File: rtl/subcarrier_map_bank.sv
// Ping-pong symbol store: two 64-bin banks, one write port, one async read
// port, and a full flag per bank handed between writer and reader.
module subcarrier_map_bank
    import ofdm_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                map_clk,
    input  logic                map_rst,
    input  logic                wr_en,
    input  logic                wr_bank,
    input  logic [5:0]          wr_addr,
    input  logic [2*DATA_W-1:0] wr_data,
    input  logic                set_full,
    input  logic                clr_full,
    input  logic                clr_bank,
    input  logic                rd_bank,
    input  logic [5:0]          rd_addr,
    output logic [2*DATA_W-1:0] rd_data,
    output logic [1:0]          full
);

    logic [2*DATA_W-1:0] mem [2*NFFT];

    always_ff @(posedge map_clk) begin
        if (wr_en)
            mem[{wr_bank, wr_addr}] <= wr_data;
    end

    assign rd_data = mem[{rd_bank, rd_addr}];

    // Writer and reader never own the same bank, so set and clear never collide.
    always_ff @(posedge map_clk) begin
        if (map_rst) begin
            full <= 2'b00;
        end else begin
            if (set_full)
                full[wr_bank] <= 1'b1;
            if (clr_full)
                full[clr_bank] <= 1'b0;
        end
    end

endmodule

// File: rtl/subcarrier_map.sv
// Reorders 52 used subcarriers into 64 IFFT bins with zeroed DC/guards.
// Define SUBCARRIER_MAP_BITREV_EN to stream bins in bit-reversed order.
module subcarrier_map
    import ofdm_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int OUT_GAP = 0
) (
    input  logic            map_clk,
    input  logic            map_rst,
    subcarrier_map_if.slave bus
);

    localparam logic [3:0] GAP_LAST = 4'((OUT_GAP > 0) ? OUT_GAP - 1 : 0);

    logic [5:0]          wr_k;
    logic                wr_bank;
    logic                accept;
    logic                wr_last;
    logic                ovf_q;
    logic [1:0]          bank_full;

    rd_state_e           state;
    rd_state_e           state_nxt;
    logic                rd_bank;
    logic [6:0]          rd_cnt;
    logic [3:0]          gap_cnt;
    logic [5:0]          rd_addr;
    logic [2*DATA_W-1:0] rd_data;
    logic                load;
    logic                out_fire;
    logic                rd_done;

    logic                dv_q;
    logic [DATA_W-1:0]   dre_q;
    logic [DATA_W-1:0]   dim_q;
    logic [5:0]          didx_q;
    logic                sop_q;
    logic                eop_q;

    // ---------------- write side ----------------
    assign bus.din_ready = !bank_full[wr_bank];
    assign accept        = bus.din_valid && !bank_full[wr_bank];
    assign wr_last       = accept && (wr_k == 6'(N_USED - 1));

    always_ff @(posedge map_clk) begin
        if (map_rst) begin
            wr_k    <= '0;
            wr_bank <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                wr_k <= wr_last ? '0 : wr_k + 6'd1;
                if (wr_last)
                    wr_bank <= ~wr_bank;
            end
            if (bus.din_valid && bank_full[wr_bank])
                ovf_q <= 1'b1;
        end
    end

    subcarrier_map_bank #(.DATA_W(DATA_W)) u_bank (
        .map_clk  (map_clk),
        .map_rst  (map_rst),
        .wr_en    (accept),
        .wr_bank  (wr_bank),
        .wr_addr  (logical_to_bin(wr_k)),
        .wr_data  ({bus.din_real, bus.din_imag}),
        .set_full (wr_last),
        .clr_full (rd_done),
        .clr_bank (rd_bank),
        .rd_bank  (rd_bank),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .full     (bank_full)
    );

    // ---------------- read side ----------------
`ifdef SUBCARRIER_MAP_BITREV_EN
    assign rd_addr = bitrev6(rd_cnt[5:0]);
`else
    assign rd_addr = rd_cnt[5:0];
`endif

    // rd_cnt[6] set means all 64 bins are loaded and bin 63 awaits acceptance.
    assign out_fire = dv_q && bus.dout_ready;
    assign load     = (state == RD_STREAM) && !rd_cnt[6] && (!dv_q || bus.dout_ready);
    assign rd_done  = (state == RD_STREAM) && rd_cnt[6] && out_fire;

    always_ff @(posedge map_clk) begin
        if (map_rst)
            state <= RD_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE: begin
                if (bank_full[rd_bank])
                    state_nxt = RD_STREAM;
            end
            RD_STREAM: begin
                if (rd_done) begin
                    if (OUT_GAP > 0)
                        state_nxt = RD_GAP;
                    else if (bank_full[~rd_bank])
                        state_nxt = RD_STREAM;
                    else
                        state_nxt = RD_IDLE;
                end
            end
            RD_GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_nxt = RD_IDLE;
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge map_clk) begin
        if (map_rst) begin
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            if (rd_done)
                rd_bank <= ~rd_bank;
            if (rd_done || (state != RD_STREAM))
                rd_cnt <= '0;
            else if (load)
                rd_cnt <= rd_cnt + 7'd1;
            gap_cnt <= (state == RD_GAP) ? gap_cnt + 4'd1 : 4'd0;
        end
    end

    // Output register holds everything while the IFFT stalls.
    always_ff @(posedge map_clk) begin
        if (map_rst) begin
            dv_q   <= 1'b0;
            dre_q  <= '0;
            dim_q  <= '0;
            didx_q <= '0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
        end else if (load) begin
            dv_q   <= 1'b1;
            dre_q  <= is_null_bin(rd_addr) ? '0 : rd_data[2*DATA_W-1 -: DATA_W];
            dim_q  <= is_null_bin(rd_addr) ? '0 : rd_data[DATA_W-1:0];
            didx_q <= rd_addr;
            sop_q  <= (rd_cnt[5:0] == 6'd0);
            eop_q  <= (rd_cnt[5:0] == 6'd63);
        end else if (out_fire) begin
            dv_q  <= 1'b0;
            sop_q <= 1'b0;
            eop_q <= 1'b0;
        end
    end

    assign bus.dout_valid = dv_q;
    assign bus.dout_real  = dre_q;
    assign bus.dout_imag  = dim_q;
    assign bus.dout_index = didx_q;
    assign bus.dout_sop   = sop_q;
    assign bus.dout_eop   = eop_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_subcarrier_map.sv
// Randomized bench for subcarrier_map with a symbol-level reference model.
module tb_subcarrier_map;

    localparam int W = 16;

    logic map_clk = 1'b0;
    logic map_rst;
    always #5 map_clk = ~map_clk;

    subcarrier_map_if #(.DATA_W(W)) bus ();

    subcarrier_map #(.DATA_W(W), .OUT_GAP(0)) dut (
        .map_clk (map_clk),
        .map_rst (map_rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [5:0]   idx;
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         sop;
        logic         eop;
    } smp_t;

    int n_checks = 0;
    int n_err    = 0;

    smp_t         exp_q[$];
    logic [W-1:0] part_re[$];
    logic [W-1:0] part_im[$];

    int cyc = 0, rdy_mode = 1;
    int acc_cnt = 0, out_cnt = 0, sop_cnt = 0, eop_cnt = 0, nr_cnt = 0;
    int sym_done_edge = 0, sop_edge = 0, pos = 0;
    bit stall_v = 0, sop_prev = 0;
    smp_t st;
    logic [W-1:0] got_re [64];
    logic [W-1:0] got_im [64];
    int           ord    [64];

    task automatic chk(input string name, input bit ok, input string msg);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: %s", name, msg);
        end
    endtask

    // Logical carrier -26..-1,+1..+26 sits at FFT bin (carrier mod 64).
    function automatic int sample_to_bin(input int k);
        int sc;
        sc = (k < 26) ? k - 26 : k - 25;
        return (sc < 0) ? sc + 64 : sc;
    endfunction

    function automatic int rev6(input int i);
        int r = 0;
        for (int b = 0; b < 6; b++)
            if (((i >> b) & 1) != 0) r = r | (1 << (5 - b));
        return r;
    endfunction

    task automatic model_symbol();
        logic [W-1:0] sre [64];
        logic [W-1:0] sim [64];
        smp_t e;
        int b;
        for (int i = 0; i < 64; i++) begin sre[i] = '0; sim[i] = '0; end
        for (int k = 0; k < 52; k++) begin
            sre[sample_to_bin(k)] = part_re[k];
            sim[sample_to_bin(k)] = part_im[k];
        end
        part_re.delete();
        part_im.delete();
        for (int i = 0; i < 64; i++) begin
`ifdef SUBCARRIER_MAP_BITREV_EN
            b = rev6(i);
`else
            b = i;
`endif
            e.idx = 6'(b); e.re = sre[b]; e.im = sim[b];
            e.sop = (i == 0); e.eop = (i == 63);
            exp_q.push_back(e);
        end
    endtask

    // Observes the bus mid-cycle: what is seen here is what the next edge uses.
    task automatic monitor();
        smp_t cur, e;
        cur = '{idx: bus.dout_index, re: bus.dout_real, im: bus.dout_imag,
                sop: bus.dout_sop, eop: bus.dout_eop};
        if (map_rst) begin
            exp_q.delete(); part_re.delete(); part_im.delete();
            stall_v = 0; sop_prev = 0;
            return;
        end
        if (bus.din_valid && bus.din_ready) begin
            acc_cnt++;
            part_re.push_back(bus.din_real);
            part_im.push_back(bus.din_imag);
            if (part_re.size() == 52) begin
                model_symbol();
                sym_done_edge = cyc + 1;
            end
        end
        if (!bus.din_ready) nr_cnt++;
        if (stall_v)
            chk("stall_hold", bus.dout_valid && (cur == st),
                $sformatf("valid=%b idx=%0d re=%h im=%h required held idx=%0d re=%h im=%h",
                          bus.dout_valid, cur.idx, cur.re, cur.im, st.idx, st.re, st.im));
        if (bus.dout_valid && bus.dout_sop && !sop_prev) sop_edge = cyc;
        sop_prev = bus.dout_valid && bus.dout_sop;
        if (bus.dout_valid && bus.dout_ready) begin
            out_cnt++;
            if (cur.sop) begin sop_cnt++; pos = 0; end
            if (cur.eop) eop_cnt++;
            if (pos < 64) begin
                ord[pos] = int'(cur.idx);
                got_re[cur.idx] = cur.re;
                got_im[cur.idx] = cur.im;
                pos++;
            end
            chk("out_expected", exp_q.size() != 0,
                $sformatf("output idx=%0d with empty model queue, required none", cur.idx));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", cur == e,
                    $sformatf("idx=%0d re=%h im=%h sop=%b eop=%b required idx=%0d re=%h im=%h sop=%b eop=%b",
                              cur.idx, cur.re, cur.im, cur.sop, cur.eop, e.idx, e.re, e.im, e.sop, e.eop));
            end
        end
        stall_v = bus.dout_valid && !bus.dout_ready;
        st      = cur;
    endtask

    task automatic tick();
        @(negedge map_clk);
        monitor();
        @(posedge map_clk);
        cyc++;
        #1;
        bus.dout_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? !bus.dout_ready : 1'b0;
    endtask

    task automatic push(input logic [W-1:0] re, input logic [W-1:0] im);
        int t = 0;
        bus.din_valid = 1'b0;
        while (!bus.din_ready && t < 4000) begin tick(); t++; end
        if (t >= 4000) chk("din_ready_timeout", 1'b0, "din_ready stayed 0, required 1");
        bus.din_valid = 1'b1; bus.din_real = re; bus.din_imag = im;
        tick();
        bus.din_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin tick(); t++; end
        chk(name, exp_q.size() == 0, $sformatf("pending=%0d required 0", exp_q.size()));
        repeat (3) tick();
    endtask

    task automatic check_reset(input string name);
        chk(name, !bus.dout_valid && bus.dout_real == '0 && bus.dout_imag == '0 &&
                  bus.dout_index == '0 && !bus.dout_sop && !bus.dout_eop &&
                  !bus.overflow && bus.din_ready,
            $sformatf("v=%b re=%h im=%h idx=%0d sop=%b eop=%b ovf=%b rdy=%b required all 0, rdy=1",
                      bus.dout_valid, bus.dout_real, bus.dout_imag, bus.dout_index,
                      bus.dout_sop, bus.dout_eop, bus.overflow, bus.din_ready));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_out, b_sop, b_eop, b_nr, b_acc;
        map_rst = 1'b1;
        bus.din_valid = 1'b0; bus.din_real = '0; bus.din_imag = '0;
        bus.dout_ready = 1'b0;
        repeat (3) tick();
        check_reset("reset_vals");
        map_rst = 1'b0;

        // Ramp
        b_out = out_cnt;
        for (int k = 0; k < 52; k++) push(W'(k + 1), W'(-(k + 1)));
        drain("ramp_drain");
        chk("ramp_count", out_cnt - b_out == 64, $sformatf("got %0d required 64", out_cnt - b_out));
        chk("ramp_latency", sop_edge - sym_done_edge == 2,
            $sformatf("got %0d cycles required 2", sop_edge - sym_done_edge));
        chk("ramp_bin38", got_re[38] == W'(1) && got_im[38] == W'(-1),
            $sformatf("got (%h,%h) required (0001,ffff)", got_re[38], got_im[38]));
        chk("ramp_bin63", got_re[63] == W'(26) && got_im[63] == W'(-26),
            $sformatf("got (%h,%h) required (001a,ffe6)", got_re[63], got_im[63]));
        chk("ramp_bin1", got_re[1] == W'(27) && got_im[1] == W'(-27),
            $sformatf("got (%h,%h) required (001b,ffe5)", got_re[1], got_im[1]));
        chk("ramp_bin26", got_re[26] == W'(52) && got_im[26] == W'(-52),
            $sformatf("got (%h,%h) required (0034,ffcc)", got_re[26], got_im[26]));
        for (int b = 27; b <= 37; b += 5)
            chk("ramp_guard", got_re[b] == '0 && got_im[b] == '0,
                $sformatf("bin %0d got (%h,%h) required (0,0)", b, got_re[b], got_im[b]));
        chk("ramp_dc", got_re[0] == '0 && got_im[0] == '0,
            $sformatf("got (%h,%h) required (0,0)", got_re[0], got_im[0]));
`ifdef SUBCARRIER_MAP_BITREV_EN
        chk("bitrev_order", ord[0] == 0 && ord[1] == 32 && ord[2] == 16 && ord[3] == 48 && ord[63] == 63,
            $sformatf("got %0d,%0d,%0d,%0d..%0d required 0,32,16,48..63", ord[0], ord[1], ord[2], ord[3], ord[63]));
`else
        chk("natural_order", ord[0] == 0 && ord[1] == 1 && ord[38] == 38 && ord[63] == 63,
            $sformatf("got %0d,%0d,%0d,%0d required 0,1,38,63", ord[0], ord[1], ord[38], ord[63]));
`endif

        // Back-to-back
        b_out = out_cnt; b_sop = sop_cnt; b_eop = eop_cnt;
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 52; k++) push(W'($urandom()), W'($urandom()));
        drain("b2b_drain");
        chk("b2b_count", out_cnt - b_out == 192, $sformatf("got %0d required 192", out_cnt - b_out));
        chk("b2b_sop_eop", sop_cnt - b_sop == 3 && eop_cnt - b_eop == 3,
            $sformatf("got sop=%0d eop=%0d required 3,3", sop_cnt - b_sop, eop_cnt - b_eop));

        // Backpressure
        rdy_mode = 2;
        b_out = out_cnt; b_nr = nr_cnt;
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 52; k++) push(W'($urandom()), W'($urandom()));
        drain("bp_drain");
        rdy_mode = 1;
        tick();
        chk("bp_ready_drop", nr_cnt - b_nr > 0, $sformatf("got %0d low cycles required >0", nr_cnt - b_nr));
        chk("bp_count", out_cnt - b_out == 256, $sformatf("got %0d required 256", out_cnt - b_out));
        chk("bp_no_ovf", bus.overflow == 1'b0, $sformatf("got %b required 0", bus.overflow));

        // Overflow
        rdy_mode = 0;
        tick();
        b_acc = acc_cnt; b_out = out_cnt;
        for (int i = 1; i <= 157; i++) begin
            bus.din_valid = 1'b1; bus.din_real = W'(i); bus.din_imag = W'(~i);
            tick();
            if (i == 104) chk("ovf_before", bus.overflow == 1'b0, $sformatf("got %b required 0", bus.overflow));
            if (i == 105) chk("ovf_after", bus.overflow == 1'b1, $sformatf("got %b required 1", bus.overflow));
        end
        bus.din_valid = 1'b0;
        tick();
        chk("ovf_accepted", acc_cnt - b_acc == 104, $sformatf("got %0d required 104", acc_cnt - b_acc));
        rdy_mode = 1;
        drain("ovf_drain");
        chk("ovf_count", out_cnt - b_out == 128, $sformatf("got %0d required 128", out_cnt - b_out));
        chk("ovf_sticky", bus.overflow == 1'b1, $sformatf("got %b required 1", bus.overflow));

        // Reset mid-symbol
        for (int k = 0; k < 30; k++) push(W'($urandom()), W'($urandom()));
        map_rst = 1'b1;
        repeat (2) tick();
        check_reset("midrst_vals");
        map_rst = 1'b0;
        b_out = out_cnt;
        for (int k = 0; k < 52; k++) push(W'($urandom()), W'($urandom()));
        drain("midrst_drain");
        chk("midrst_count", out_cnt - b_out == 64, $sformatf("got %0d required 64", out_cnt - b_out));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
